fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the PC/next-PC datapath and instruction memory. Owns the fetch PC register, issues one-outstanding-request fetches over a req/gnt/rvalid handshake, and delivers fetched words to decode through a one-entry valid/ready output buffer. Applies taken-branch/jump redirects at any point, flushing the buffered instruction and discarding any in-flight response.

---
 rtl/fetch_ctrl_if.sv | 39 +++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Redirect, instruction-memory and decode-side signals of fetch_ctrl
// Revision : 1.0
// ============================================================================
interface fetch_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [31:0] pc;

   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      output pc
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      input  pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch PC owner, single-outstanding imem fetch, one-entry inst buffer
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic     clk,
   input  wire logic     rst,
   fetch_ctrl_if.master  bus
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic [1:0]  state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] req_pc_q,     req_pc_d;
   logic        drop_q,       drop_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q,       inst_d;
   logic [31:0] inst_pc_q,    inst_pc_d;

   logic        w_imem_req;
   logic        w_grant;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'h0;
         drop_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode: a request is never raised in a redirect cycle
   // ------------------------------------------------------------------------
   always_comb begin
      w_imem_req = 1'b0;
      case (state_q)
         S_REQ:   w_imem_req = !bus.redirect_valid;
         S_WAIT:  w_imem_req = 1'b0;
         S_FULL:  w_imem_req = bus.inst_ready && !bus.redirect_valid;
         default: w_imem_req = 1'b0;
      endcase
   end

   assign w_grant = w_imem_req && bus.imem_gnt;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      drop_d       = drop_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;

      if (bus.redirect_valid) begin
         pc_d         = bus.redirect_pc;
         inst_valid_d = 1'b0;
      end

      case (state_q)
         S_REQ: begin
            if (w_grant) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = S_WAIT;
            end
         end

         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (drop_q || bus.redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d       = bus.imem_rdata;
                  inst_pc_d    = req_pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_FULL;
               end
            end else if (bus.redirect_valid) begin
               // One outstanding response at most, so a single flag covers
               // any number of redirects before it lands.
               drop_d = 1'b1;
            end
         end

         S_FULL: begin
            if (bus.redirect_valid) begin
               state_d = S_REQ;
            end else if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               if (w_grant) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = S_WAIT;
               end else begin
                  state_d = S_REQ;
               end
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   assign bus.imem_req   = w_imem_req;
   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;

`ifndef SYNTHESIS
   a_rvalid_only_in_wait : assert property (
      @(posedge clk) disable iff (rst) bus.imem_rvalid |-> (state_q == S_WAIT)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl with a 1-cycle imem
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic        pend    = 1'b0;
   logic [31:0] paddr   = 32'h0;
   logic        resp_en = 1'b1;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance one clock; the memory answers one cycle after each grant.
   task automatic step();
      logic        g;
      logic        dl;
      logic        r;
      logic [31:0] ga;
      g  = bus.imem_req && bus.imem_gnt;
      ga = bus.imem_addr;
      dl = bus.imem_rvalid;
      r  = rst;
      @(posedge clk);
      #1;
      if (r) begin
         pend = 1'b0;
      end else begin
         if (dl) pend = 1'b0;
         if (g) begin
            pend  = 1'b1;
            paddr = ga;
         end
      end
      bus.imem_rvalid = pend && resp_en;
      bus.imem_rdata  = pend ? mem_word(paddr) : 32'h0;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_gnt       = 1'b1;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.inst_ready     = 1'b0;

      step(); step(); settle();
      chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rst_pc",         bus.pc,        32'h0);
      chk("rst_addr",       bus.imem_addr, 32'h0);
      chk("rst_req",        {31'b0, bus.imem_req}, 32'd1);
      chk("rst_inst",       bus.inst,      32'h0);
      chk("rst_inst_pc",    bus.inst_pc,   32'h0);

      // Free run
      rst = 1'b0; bus.inst_ready = 1'b1; settle();
      chk("run_req0",  {31'b0, bus.imem_req}, 32'd1);
      chk("run_addr0", bus.imem_addr, 32'h0);
      step(); settle();
      chk("run_wait_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("run_wait_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("run_wait_pc",    bus.pc, 32'h4);
      step(); settle();
      chk("run_valid0",   {31'b0, bus.inst_valid}, 32'd1);
      chk("run_inst_pc0", bus.inst_pc, 32'h0);
      chk("run_inst0",    bus.inst, mem_word(32'h0));
      chk("run_req1",     {31'b0, bus.imem_req}, 32'd1);
      chk("run_addr1",    bus.imem_addr, 32'h4);
      step(); settle();
      chk("run_gap_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("run_gap_pc",    bus.pc, 32'h8);
      step(); bus.inst_ready = 1'b0; settle();

      // Backpressure
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",   {31'b0, bus.inst_valid}, 32'd1);
         chk("bp_inst_pc", bus.inst_pc, 32'h4);
         chk("bp_inst",    bus.inst, mem_word(32'h4));
         chk("bp_req",     {31'b0, bus.imem_req}, 32'd0);
         chk("bp_pc",      bus.pc, 32'h8);
         step(); settle();
      end
      bus.inst_ready = 1'b1; resp_en = 1'b0; settle();
      chk("bp_release_req",  {31'b0, bus.imem_req}, 32'd1);
      chk("bp_release_addr", bus.imem_addr, 32'h8);

      // Redirect while waiting for addr 0x8
      step();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; resp_en = 1'b1; settle();
      chk("rw_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("rw_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rw_pc",    bus.pc, 32'hC);
      step(); bus.redirect_valid = 1'b0; settle();
      chk("rw_stale_req",   {31'b0, bus.imem_req}, 32'd0);
      chk("rw_stale_pc",    bus.pc, 32'h100);
      chk("rw_stale_valid", {31'b0, bus.inst_valid}, 32'd0);
      step(); settle();
      chk("rw_drop_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rw_new_req",    {31'b0, bus.imem_req}, 32'd1);
      chk("rw_new_addr",   bus.imem_addr, 32'h100);
      step(); settle();
      chk("rw_wait_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rw_wait_pc",    bus.pc, 32'h104);
      step(); settle();
      chk("rw_valid1",  {31'b0, bus.inst_valid}, 32'd1);
      chk("rw_inst_pc", bus.inst_pc, 32'h100);
      chk("rw_inst",    bus.inst, mem_word(32'h100));

      // Redirect in S_FULL together with inst_ready
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2000; settle();
      chk("rf_req", {31'b0, bus.imem_req}, 32'd0);
      step(); bus.redirect_valid = 1'b0; settle();
      chk("rf_valid", {31'b0, bus.inst_valid}, 32'd0);
      chk("rf_req2",  {31'b0, bus.imem_req}, 32'd1);
      chk("rf_addr",  bus.imem_addr, 32'h2000);
      step(); step(); settle();
      chk("rf_inst_pc", bus.inst_pc, 32'h2000);
      chk("rf_inst",    bus.inst, mem_word(32'h2000));

      // Wrap-around
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; settle();
      step(); bus.redirect_valid = 1'b0; settle();
      chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
      chk("wr_req",  {31'b0, bus.imem_req}, 32'd1);
      step(); settle();
      chk("wr_pc", bus.pc, 32'h0);
      step(); settle();
      chk("wr_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
      chk("wr_inst",    bus.inst, mem_word(32'hFFFF_FFFC));
      chk("wr_addr0",   bus.imem_addr, 32'h0);
      chk("wr_req0",    {31'b0, bus.imem_req}, 32'd1);

      // Stalled memory, then redirect while ungranted
      bus.imem_gnt = 1'b0; settle();
      step(); settle();
      chk("st_valid", {31'b0, bus.inst_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("st_req",  {31'b0, bus.imem_req}, 32'd1);
         chk("st_addr", bus.imem_addr, 32'h0);
         step(); settle();
      end
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; settle();
      chk("st_redir_req", {31'b0, bus.imem_req}, 32'd0);
      step();
      bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b1; resp_en = 1'b0; settle();
      chk("st_req40",  {31'b0, bus.imem_req}, 32'd1);
      chk("st_addr40", bus.imem_addr, 32'h40);
      step(); settle();
      chk("st_wait_pc",  bus.pc, 32'h44);
      chk("st_wait_req", {31'b0, bus.imem_req}, 32'd0);

      // Reset during S_WAIT
      rst = 1'b1; step(); settle();
      chk("mr_req",     {31'b0, bus.imem_req}, 32'd1);
      chk("mr_addr",    bus.imem_addr, 32'h0);
      chk("mr_pc",      bus.pc, 32'h0);
      chk("mr_valid",   {31'b0, bus.inst_valid}, 32'd0);
      chk("mr_inst",    bus.inst, 32'h0);
      chk("mr_inst_pc", bus.inst_pc, 32'h0);
      rst = 1'b0; resp_en = 1'b1; settle();
      step(); step(); settle();
      chk("mr_refetch_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("mr_refetch_pc",    bus.inst_pc, 32'h0);
      chk("mr_refetch_inst",  bus.inst, mem_word(32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
